// File: rtl/uart_pkg.sv
// Shared definitions for the wishbone UART transmitter: register map, status bits, serialiser states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package uart_pkg;

    // Word addresses of the register map; address 3 is reserved.
    localparam logic [1:0] ADDR_TXDATA  = 2'd0;
    localparam logic [1:0] ADDR_STATUS  = 2'd1;
    localparam logic [1:0] ADDR_DIVISOR = 2'd2;

    // Bit positions inside the STATUS register.
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    // Serialiser state encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
// Latency: a pushed word is visible on dout the cycle after the push.
// Backpressure: push while full is dropped unless a pop frees the slot in the same cycle; pop while empty is ignored.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the low bits match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/wb_uart_tx.sv
// Wishbone-classic slave that queues bytes in a TX FIFO and sends them 8N1 on o_tx.
// Latency: ack one cycle after request; first start bit two cycles after the TXDATA write request.
// Backpressure: none on the bus; writes to a full FIFO are acked, dropped, and flagged as sticky overflow.
module wb_uart_tx
    import uart_pkg::*;
#(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [15:0] DIV_RESET  = 16'd3
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic [1:0]  i_wb_addr,
    input  logic [31:0] i_wb_data,
    input  logic [3:0]  i_wb_sel,
    output logic [31:0] o_wb_data,
    output logic        o_wb_ack,
    output logic        o_tx,
    output logic        o_irq
);

    logic        req;
    logic        wr_req;
    logic        rd_req;
    logic [15:0] div;
    logic        overflow;
    state_t      state;
    logic [7:0]  shift;
    logic [15:0] bit_div;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [31:0] status_word;
    logic [31:0] rd_mux;
    logic        unused_bits;

    // A held strobe only counts as a new request in cycles where no ack is out.
    assign req    = i_wb_cyc & i_wb_stb & ~o_wb_ack;
    assign wr_req = req & i_wb_we;
    assign rd_req = req & ~i_wb_we;

    assign fifo_push = wr_req & (i_wb_addr == ADDR_TXDATA) & i_wb_sel[0];
    assign fifo_pop  = (state == ST_IDLE) & ~fifo_empty;

    assign unused_bits = &{1'b0, i_wb_data[31:16], i_wb_sel[3:2]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (i_clk),
        .rst_n (i_reset_n),
        .push  (fifo_push),
        .din   (i_wb_data[7:0]),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Assemble STATUS and select the read word for the addressed register.
    always_comb begin
        status_word            = '0;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_BUSY]  = (state != ST_IDLE);
        status_word[STAT_OVF]   = overflow;
        case (i_wb_addr)
            ADDR_STATUS:  rd_mux = status_word;
            ADDR_DIVISOR: rd_mux = {16'd0, div};
            default:      rd_mux = '0;
        endcase
    end

    // Bus response: single-cycle ack, read data only present alongside it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack  <= i_wb_cyc & i_wb_stb & ~o_wb_ack;
            o_wb_data <= rd_req ? rd_mux : 32'd0;
        end
    end

    // Divisor register and sticky overflow flag.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            div      <= DIV_RESET;
            overflow <= 1'b0;
        end else begin
            if (wr_req && i_wb_addr == ADDR_DIVISOR) begin
                if (i_wb_sel[0]) div[7:0]  <= i_wb_data[7:0];
                if (i_wb_sel[1]) div[15:8] <= i_wb_data[15:8];
            end
            if (wr_req && i_wb_addr == ADDR_STATUS && i_wb_sel[0] && i_wb_data[STAT_OVF]) begin
                overflow <= 1'b0;
            end else if (fifo_push && fifo_full && !fifo_pop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Serialiser: start, eight data bits LSB first, stop; bit period latched per frame.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= ST_IDLE;
            shift   <= '0;
            bit_div <= '0;
            cnt     <= '0;
            bit_idx <= '0;
            o_tx    <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_tx <= 1'b1;
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        bit_div <= div;
                        cnt     <= div;
                        o_tx    <= 1'b0;
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (cnt == 16'd0) begin
                        cnt     <= bit_div;
                        bit_idx <= 3'd0;
                        o_tx    <= shift[0];
                        state   <= ST_DATA;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (cnt == 16'd0) begin
                        cnt <= bit_div;
                        if (bit_idx == 3'd7) begin
                            o_tx  <= 1'b1;
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            o_tx    <= shift[1];
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_STOP: begin
                    o_tx <= 1'b1;
                    if (cnt == 16'd0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Drain interrupt: nothing queued and nothing on the wire.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_irq <= 1'b1;
        end else begin
            o_irq <= fifo_empty & (state == ST_IDLE);
        end
    end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Scoreboard bench for wb_uart_tx: bus reads and serial frames are checked by independent monitors.
// Latency: n/a.
// Backpressure: n/a.
module tb_wb_uart_tx;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [1:0]  i_wb_addr = 2'd0;
    logic [31:0] i_wb_data = 32'd0;
    logic [3:0]  i_wb_sel = 4'd0;
    logic [31:0] o_wb_data;
    logic        o_wb_ack;
    logic        o_tx;
    logic        o_irq;

    wb_uart_tx #(
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd3)
    ) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_wb_cyc  (i_wb_cyc),
        .i_wb_stb  (i_wb_stb),
        .i_wb_we   (i_wb_we),
        .i_wb_addr (i_wb_addr),
        .i_wb_data (i_wb_data),
        .i_wb_sel  (i_wb_sel),
        .o_wb_data (o_wb_data),
        .o_wb_ack  (o_wb_ack),
        .o_tx      (o_tx),
        .o_irq     (o_irq)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;

    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          tag;
    } bus_exp_t;

    typedef struct {
        logic [7:0] data;
        int         bitclk;
        int         start;
        bit         abort;
    } frame_exp_t;

    bus_exp_t   bus_q[$];
    frame_exp_t frame_q[$];
    bit         mon_busy = 1'b0;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // One bus transfer; returns the cycle index in which the request was presented.
    task automatic wb_cycle(input bit we, input logic [1:0] addr, input logic [31:0] data,
                            input logic [3:0] sel, output int req_cyc);
        bit got;
        got = 1'b0;
        @(posedge i_clk);
        #1;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        i_wb_sel  = sel;
        req_cyc   = cyc_n;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk);
            #1;
            if (o_wb_ack) begin
                got = 1'b1;
                break;
            end
        end
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        chk(got, "ack_timeout", got, 1);
    endtask

    task automatic wb_write(input logic [1:0] addr, input logic [31:0] data, input logic [3:0] sel);
        bus_exp_t e;
        int k;
        e.rd = 1'b0; e.data = 32'd0; e.tag = 0;
        bus_q.push_back(e);
        wb_cycle(1'b1, addr, data, sel, k);
    endtask

    task automatic wb_read(input logic [1:0] addr, input logic [31:0] exp, input int tag);
        bus_exp_t e;
        int k;
        e.rd = 1'b1; e.data = exp; e.tag = tag;
        bus_q.push_back(e);
        wb_cycle(1'b0, addr, 32'd0, 4'hF, k);
    endtask

    task automatic send_byte(input logic [7:0] d, input int bitclk, input bit chk_start,
                             input bit abort, output int req_cyc);
        frame_exp_t f;
        bus_exp_t e;
        e.rd = 1'b0; e.data = 32'd0; e.tag = 0;
        bus_q.push_back(e);
        wb_cycle(1'b1, 2'd0, {24'd0, d}, 4'h1, req_cyc);
        f.data = d; f.bitclk = bitclk; f.abort = abort;
        f.start = chk_start ? req_cyc + 2 : -1;
        frame_q.push_back(f);
    endtask

    task automatic wait_frames(input int limit);
        for (int i = 0; i < limit && (frame_q.size() != 0 || mon_busy); i++) @(negedge i_clk);
        chk(frame_q.size() == 0 && !mon_busy, "frames_drain", frame_q.size(), 0);
    endtask

    // Bus monitor: every ack consumes one expectation; reads compare data.
    initial begin : bus_mon
        bus_exp_t e;
        forever begin
            @(negedge i_clk);
            if (o_wb_ack === 1'b1) begin
                if (bus_q.size() == 0) begin
                    chk(1'b0, "unexpected_ack", 1, 0);
                end else begin
                    e = bus_q.pop_front();
                    if (e.rd) chk(o_wb_data === e.data, $sformatf("read_%0d", e.tag), o_wb_data, e.data);
                end
            end else if (i_wb_cyc && i_reset_n) begin
                chk(o_wb_data === 32'd0, "rdata_outside_ack", o_wb_data, 0);
            end
        end
    end

    // Frame monitor: every start bit consumes one expected frame and is checked cycle by cycle.
    initial begin : frame_mon
        frame_exp_t f;
        logic [9:0] pat;
        logic [7:0] rx;
        bit         bad;
        bit         aborted;
        forever begin
            @(negedge i_clk);
            if (i_reset_n === 1'b1 && o_tx === 1'b0) begin
                if (frame_q.size() == 0) begin
                    chk(1'b0, "spurious_frame", cyc_n, 0);
                    while (o_tx === 1'b0) @(negedge i_clk);
                end else begin
                    mon_busy = 1'b1;
                    f = frame_q.pop_front();
                    if (f.start >= 0) chk(cyc_n == f.start, "start_cycle", cyc_n, f.start);
                    pat = {1'b1, f.data, 1'b0};
                    rx = 8'd0; bad = 1'b0; aborted = 1'b0;
                    for (int c = 0; c < 10 * f.bitclk; c++) begin
                        if (c > 0) @(negedge i_clk);
                        if (i_reset_n !== 1'b1) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (o_tx !== pat[c / f.bitclk]) bad = 1'b1;
                        if ((c / f.bitclk) >= 1 && (c / f.bitclk) <= 8 && (c % f.bitclk) == f.bitclk / 2)
                            rx[(c / f.bitclk) - 1] = o_tx;
                    end
                    if (aborted) chk(f.abort, "frame_aborted", 1, f.abort);
                    else chk(!f.abort && !bad && rx == f.data, $sformatf("frame_bits_b%0d", f.bitclk),
                             {bad, f.abort, rx}, {2'b00, f.data});
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : stim
        int k;
        logic [5:0] ack_pat;
        logic [5:0] exp_pat;
        bus_exp_t   e;

        // Reset with random bus activity.
        repeat (5) begin
            @(posedge i_clk);
            #1;
            i_wb_cyc  = 1'($urandom);
            i_wb_stb  = 1'($urandom);
            i_wb_we   = 1'($urandom);
            i_wb_addr = 2'($urandom);
            i_wb_data = $urandom;
            i_wb_sel  = 4'($urandom);
        end
        chk(o_tx === 1'b1, "reset_tx", o_tx, 1);
        chk(o_wb_ack === 1'b0, "reset_ack", o_wb_ack, 0);
        chk(o_irq === 1'b1, "reset_irq", o_irq, 1);
        chk(o_wb_data === 32'd0, "reset_rdata", o_wb_data, 0);
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0; i_wb_we = 1'b0;
        @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        wb_read(2'd1, 32'h2, 1);

        // Single byte at the reset divisor (4-clock bits).
        send_byte(8'hA5, 4, 1'b1, 1'b0, k);
        repeat (10) @(negedge i_clk);
        chk(o_irq === 1'b0, "irq_during_frame", o_irq, 0);
        wait_frames(200);
        repeat (3) @(negedge i_clk);
        chk(o_irq === 1'b1, "irq_after_frame", o_irq, 1);

        // Held strobe on a STATUS read: ack every other cycle.
        e.rd = 1'b1; e.data = 32'h2; e.tag = 2;
        repeat (3) bus_q.push_back(e);
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b1; i_wb_stb = 1'b1; i_wb_we = 1'b0; i_wb_addr = 2'd1; i_wb_sel = 4'hF;
        ack_pat = '0;
        repeat (6) begin
            @(negedge i_clk);
            ack_pat = {ack_pat[4:0], o_wb_ack};
        end
        @(posedge i_clk);
        #1;
        i_wb_cyc = 1'b0; i_wb_stb = 1'b0;
        exp_pat = 6'b010101;
        chk(ack_pat == exp_pat, "ack_pattern", ack_pat, exp_pat);

        // Divisor 0: one-clock bits, 10-clock frame.
        wb_write(2'd2, 32'd0, 4'h3);
        send_byte(8'h00, 1, 1'b1, 1'b0, k);
        wait_frames(100);

        // Divisor change mid-frame only affects the next frame.
        wb_write(2'd2, 32'd3, 4'h3);
        send_byte(8'h3C, 4, 1'b1, 1'b0, k);
        send_byte(8'hC3, 8, 1'b0, 1'b0, k);
        repeat (4) @(posedge i_clk);
        wb_write(2'd2, 32'd7, 4'h3);
        wait_frames(300);
        wb_read(2'd2, 32'h7, 3);

        // Byte-select gating on DIVISOR.
        wb_write(2'd2, 32'h0000AB07, 4'h3);
        wb_write(2'd2, 32'h00001234, 4'h1);
        wb_read(2'd2, 32'h0000AB34, 4);
        wb_write(2'd2, 32'h00005600, 4'h2);
        wb_read(2'd2, 32'h00005634, 5);

        // Reserved address: read zero, write ignored, still acked.
        wb_write(2'd3, 32'hFFFFFFFF, 4'hF);
        wb_read(2'd3, 32'h0, 6);
        wb_read(2'd0, 32'h0, 7);

        // Fill and overflow at divisor 100.
        wb_write(2'd2, 32'd100, 4'h3);
        for (int i = 0; i < 10; i++) begin
            if (i < 9) send_byte(8'h10 + 8'(i), 101, 1'b0, 1'b0, k);
            else wb_write(2'd0, 32'h19, 4'h1);
        end
        wb_read(2'd1, 32'hD, 8);
        wb_write(2'd1, 32'h8, 4'h1);
        wb_read(2'd1, 32'h5, 9);
        wait_frames(12000);
        repeat (20) @(negedge i_clk);
        wb_read(2'd1, 32'h2, 10);

        // Reset in the middle of bit 3 of 0x55.
        wb_write(2'd2, 32'd3, 4'h3);
        send_byte(8'h55, 4, 1'b1, 1'b1, k);
        while (cyc_n < k + 19) begin
            @(posedge i_clk);
            #1;
        end
        #1;
        chk(o_tx === 1'b0, "tx_bit3_before_reset", o_tx, 0);
        i_reset_n = 1'b0;
        #1;
        chk(o_tx === 1'b1, "tx_async_reset", o_tx, 1);
        repeat (3) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        repeat (100) @(negedge i_clk);
        chk(frame_q.size() == 0 && !mon_busy, "no_frame_after_reset", frame_q.size(), 0);
        wb_read(2'd1, 32'h2, 11);
        repeat (3) @(negedge i_clk);
        chk(bus_q.size() == 0, "bus_drain", bus_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_uart_tx.md
Name: wb_uart_tx

Overview:
- Wishbone-classic slave peripheral that sits on the soc data bus, downstream of the CPU's memory port.
- Accepts byte writes into a TX FIFO and serialises them 8N1 on o_tx.
- Exposes status and baud-divisor registers, and raises a level interrupt when transmission has drained.
- Gives directed benches a visible serial output.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of two, at least 2.
- DIV_RESET, 16'd3, divisor value loaded at reset; bit time is DIV+1 clocks.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_wb_cyc  in  1  bus cycle.
- i_wb_stb  in  1  strobe.
- i_wb_we  in  1  write enable.
- i_wb_addr  in  2  word address: 0=TXDATA, 1=STATUS, 2=DIVISOR, 3=reserved.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte selects.
- o_wb_data  out  32  read data.
- o_wb_ack  out  1  single-cycle acknowledge.
- o_tx  out  1  serial line, idle high.
- o_irq  out  1  high when the FIFO is empty and the serialiser is idle.

Behaviour:
- Reset values (async on i_reset_n low): o_wb_ack=0, o_wb_data=0, o_tx=1, o_irq=1, FIFO empty, overflow=0, DIV=DIV_RESET, FSM=IDLE.
- Bus handshake:
  - o_wb_ack <= i_wb_cyc & i_wb_stb & ~o_wb_ack, so ack comes 1 cycle after the request and lasts 1 cycle.
  - A held strobe is acked every other cycle.
  - All side effects occur on the request cycle that generates the ack, never on the ack cycle.
  - o_wb_data is valid in the ack cycle and 0 otherwise.
- TXDATA write (sel[0]=1):
  - Pushes data[7:0] into the FIFO.
  - If the FIFO is full, the byte is dropped, the sticky overflow bit is set, and the ack is still given.
  - sel[0]=0: no push.
  - TXDATA reads return 0.
- STATUS register:
  - Read: bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bit3 overflow, bits 31:4 = 0.
  - Write with data[3]=1 and sel[0]=1 clears overflow; all other bits are ignored.
- DIVISOR register:
  - Read/write on bits 15:0; sel[0] and sel[1] gate the low and high bytes.
  - Reads return DIV zero-extended.
- FIFO:
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - full = MSBs differ and low bits equal; empty = pointers equal.
  - A simultaneous push and pop when full is allowed: the pop frees the slot in the same cycle, so the push succeeds with no overflow.
  - A simultaneous push and pop when empty: the pop does not occur (FSM sees empty); the push lands.
- Serialiser FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop the head into a shift register, latch DIV into bit_div, go to START. o_tx=1.
  - START: o_tx=0 for bit_div+1 clocks, then go to DATA with bit index 0.
  - DATA: o_tx=shift[0], LSB first. Each bit lasts bit_div+1 clocks; shift right. After bit 7, go to STOP.
  - STOP: o_tx=1 for bit_div+1 clocks, then go to IDLE.
  - The first START cycle is 1 clock after the IDLE pop. Back-to-back bytes leave exactly 1 extra idle-high clock between STOP and the next START.
- Bit counter: 16-bit, counts down from bit_div to 0.
  - A DIVISOR write mid-frame has no effect until the next frame's latch.
  - DIV=0 gives a 1-clock bit.
- o_tx is driven from a register (glitch-free).
- o_irq = empty & (FSM==IDLE), registered.
- Reserved address: reads return 0, writes are ignored, ack is still given.
- Reset asserted mid-frame: o_tx returns to 1 immediately, FIFO contents are discarded, no partial frame resumes.

Decomposition:
- Shared package uart_pkg holds:
  - register address constants ADDR_TXDATA=0, ADDR_STATUS=1, ADDR_DIVISOR=2;
  - STATUS bit indices;
  - FSM state encoding (2-bit localparams).
- Sub-module sync_fifo: parameterised width 8 and depth, with push, pop, full, empty, and dout as the head word (first-word-fall-through).
  - The bus decode and the serialiser stay in wb_uart_tx.

Test Plan:
- Reset:
  - Hold i_reset_n=0 for 5 cycles with random bus inputs -> o_tx=1, o_wb_ack=0, o_irq=1.
  - Then read STATUS -> 0x00000002.
- Single byte:
  - DIV=3, write TXDATA=0xA5 -> o_tx low for 4 clocks starting 2 cycles after the request.
  - Then bits 1,0,1,0,0,1,0,1 at 4 clocks each, then high for 4; o_irq falls during the frame and rises after STOP.
- Fill/overflow:
  - FIFO_DEPTH=8, DIV=100, write 10 bytes back-to-back -> STATUS shows full=1 and overflow=1 once the FIFO fills; the surplus writes are dropped.
  - Later, exactly 9 frames appear on o_tx (8 queued + 1 popped into the FSM before the FIFO filled).
  - Write STATUS=0x8 -> overflow=0.
- Divisor:
  - Write DIVISOR=0, send 0x00 -> frame is 10 clocks long.
  - Write DIVISOR=7 mid-frame -> current frame is unchanged, next frame uses 8-clock bits.
  - Write with sel=4'b0001, data=0x1234 -> DIVISOR reads 0x0034 plus the prior high byte.
- Ack protocol: hold cyc=stb=1 for 6 cycles on a STATUS read -> ack pattern 0,1,0,1,0,1 and o_wb_data nonzero only in ack cycles.
- Mid-frame reset: assert i_reset_n=0 during bit 3 of 0x55 -> o_tx=1 asynchronously; after release, no further frame is emitted and STATUS=0x2.
